seg7_capture: RTL and testbench
===============================

# seg7_capture

Decodes a time-multiplexed, active-low 7-segment display bus back into BCD digits. It samples the anode and segment lines driven by the display scanner and waits for each digit's pattern to hold steady. It then decodes each stable pattern and assembles one frame per full scan. Each frame is presented through a valid/ready handshake. The block sits on the observation side of the display path, for self-test and readback of what the panel is showing.

## Interface
- DIGITS, 4: number of multiplexed digits (anode lines).
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..255.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- an_n  input  DIGITS  anode enables, active-low; bit i selects digit i.
- seg_n  input  [0:6]  segments a..g, active-low; bit 0 = a, bit 6 = g.
- digits  output  4*DIGITS  decoded BCD; digit i occupies bits [4i+3:4i].
- err  output  DIGITS  bit i set if digit i's pattern was not a legal 0-9 glyph.
- frame_valid  output  1  frame available on digits/err.
- frame_ready  input  1  consumer accepts the frame.
- overrun  output  1  a completed frame was dropped while frame_valid was held.

## Operation
- an_n and seg_n are registered once on entry. Input registers reset to all-ones, meaning inactive.
- A sample is "single-anode" when exactly one an_n bit is 0.
  - Zero or multiple active anodes means blank or ghosting.
  - Such a sample returns the FSM to IDLE and clears the stability counter.
- FSM states:
  - IDLE: no valid single-anode sample.
    - Single-anode sample -> SETTLE, counter = 1.
  - SETTLE: if the sample equals the previous one (both an_n and seg_n), counter increments; any change resets counter to 1.
    - When counter reaches STABLE_CYCLES: decode, write the slot for the active anode, set its bit in the captured mask, go to CAPTURED.
  - CAPTURED: hold while the sample is unchanged; no second capture in the same window.
    - Any change -> SETTLE (new single-anode sample) or IDLE.
- Decode table (abcdefg, active-low):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Any other pattern: slot value 4'hF, slot error bit = 1.
- A digit recaptured before the frame completes overwrites its slot; latest wins.
- When the captured mask becomes all ones, the frame completes: slots and error bits move to the output stage and the mask clears.
  - If frame_valid=0: load digits/err, set frame_valid.
  - If frame_valid=1 and frame_ready=1 that cycle: load the new frame; frame_valid stays 1.
  - If frame_valid=1 and frame_ready=0: discard the new frame, set overrun; outputs unchanged.
- Handshake:
  - The frame is accepted on a rising edge with frame_valid=1 and frame_ready=1. frame_valid drops next cycle unless a new frame loads simultaneously.
  - digits/err are stable while frame_valid=1.
  - overrun clears on acceptance unless a new drop occurs on the same edge; drop wins.
- Reset mid-scan discards partial slots and the mask; no partial frame is ever presented.

## Timing
- Reset values: digits=0, err=0, frame_valid=0, overrun=0; FSM=IDLE, counter=0, mask=0, slots=0.
- If an_n/seg_n are constant at the pins for rising edges k..k+STABLE_CYCLES-1 (after an IDLE or different prior sample):
  - The slot is written at edge k+STABLE_CYCLES.
  - If this completes the frame, frame_valid is high after edge k+STABLE_CYCLES+1.
- Windows shorter than STABLE_CYCLES samples are never captured.
- No combinational path from inputs to outputs; frame_ready affects outputs only at the next edge.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-SETTLE, then release.
  - Response: all outputs 0, no frame until four fresh captures.
- Clean scan, STABLE_CYCLES=4, frame_ready=1:
  - Stimulus: an_n=1110/1101/1011/0111, 6 cycles each, patterns for 1,2,3,4.
  - Response: digits=16'h4321, err=0, one frame_valid pulse at the edge given in Timing.
- Glitch rejection:
  - Stimulus: digit 0 shows 0000001 for 3 cycles, then 0000110 for 5 cycles.
  - Response: slot 0 = 3; 3-cycle window ignored.
- Illegal glyph and ghosting:
  - Stimulus: digit 2 shows 1111111; an_n=1100 inserted between digits.
  - Response: digit 2 = 4'hF, err=4'b0100; ghost sample captures nothing.
- Backpressure:
  - Stimulus: frame_ready=0 across two complete scans.
  - Response: first frame held unchanged, overrun=1 after second completion.
  - Then raise frame_ready for 1 cycle: frame_valid=0, overrun=0 next cycle.
- Simultaneous accept and complete:
  - Stimulus: frame_ready=1 on the same edge the next frame completes.
  - Response: new digits loaded, frame_valid stays 1, overrun=0.

Source files
------------

// File: rtl/seg7_capture.sv
// Observes a multiplexed active-low 7-segment bus, captures each digit once its
// pattern has been stable long enough, and emits one decoded frame per full scan.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS-1:0]   an_n,
    input  logic [0:6]          seg_n,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   err,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

    localparam logic [7:0] STABLE_U8 = 8'(STABLE_CYCLES);

    logic [DIGITS-1:0]   an_reg, an_prev_reg;
    logic [0:6]          seg_reg, seg_prev_reg;
    state_t              state_reg, state_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [DIGITS-1:0]   mask_reg, mask_next;
    logic [DIGITS-1:0]   sel;
    logic                single;
    logic                same;
    logic                capture;
    logic                frame_done;
    logic [3:0]          dec_val;
    logic                dec_err;
    logic [4*DIGITS-1:0] slot_vals;
    logic [DIGITS-1:0]   slot_errs;

    // Input sampling plus one sample of history for the stability comparison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg       <= '1;
            seg_reg      <= '1;
            an_prev_reg  <= '1;
            seg_prev_reg <= '1;
        end else begin
            an_reg       <= an_n;
            seg_reg      <= seg_n;
            an_prev_reg  <= an_reg;
            seg_prev_reg <= seg_reg;
        end
    end

    assign sel    = ~an_reg;
    assign single = $onehot(sel);
    assign same   = (an_reg == an_prev_reg) && (seg_reg == seg_prev_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mask_reg  <= mask_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (!single) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = SETTLE;
                    cnt_next   = 8'd1;
                end
                SETTLE: begin
                    if (!same) begin
                        cnt_next = 8'd1;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                        if (cnt_reg + 8'd1 == STABLE_U8) begin
                            capture    = 1'b1;
                            state_next = CAPTURED;
                        end
                    end
                end
                CAPTURED: begin
                    if (!same) begin
                        state_next = SETTLE;
                        cnt_next   = 8'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // A full mask is handed to the output stage one edge after the last capture
    assign frame_done = &mask_reg;
    assign mask_next  = (frame_done ? '0 : mask_reg) | (capture ? sel : '0);

    always_comb begin
        dec_val = 4'hF;
        dec_err = 1'b0;
        case (seg_reg)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            default:    dec_err = 1'b1;
        endcase
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
        logic [3:0] val_reg;
        logic       err_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_reg <= '0;
                err_reg <= 1'b0;
            end else if (capture && sel[gi]) begin
                val_reg <= dec_val;
                err_reg <= dec_err;
            end
        end

        assign slot_vals[4*gi +: 4] = val_reg;
        assign slot_errs[gi]        = err_reg;
    end

    // Output stage: a completed frame loads only if the slot is free or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (frame_done) begin
            if (!frame_valid || frame_ready) begin
                digits      <= slot_vals;
                err         <= slot_errs;
                frame_valid <= 1'b1;
                if (frame_valid) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scans from the test plan plus a randomized
// scan phase, all checked every cycle against a run-length reference model.
module tb_seg7_capture;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DIGITS-1:0]   an_n;
    logic [0:6]          seg_n;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   err;
    logic                frame_valid;
    logic                frame_ready;
    logic                overrun;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .an_n(an_n), .seg_n(seg_n),
        .digits(digits), .err(err), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] gl(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: counts runs of identical single-anode pin samples.
    // The S-th sample of a run captures one edge later; a full set of four
    // captures reaches the outputs one edge after that.
    logic [DIGITS-1:0]   m_prev_an, m_prev2_an;
    logic [0:6]          m_prev_seg, m_prev2_seg;
    int                  m_run;
    logic [3:0]          m_slot [DIGITS];
    logic                m_serr [DIGITS];
    logic [DIGITS-1:0]   m_mask;
    logic                m_cpend;
    logic [4*DIGITS-1:0] m_fd, m_dig;
    logic [DIGITS-1:0]   m_fe, m_err;
    logic                m_fv, m_ovr;

    task automatic model_reset();
        m_prev_an = '1; m_prev2_an = '1; m_prev_seg = '1; m_prev2_seg = '1;
        m_run = 0; m_mask = '0; m_cpend = 1'b0;
        m_fd = '0; m_fe = '0; m_dig = '0; m_err = '0; m_fv = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            m_slot[i] = '0;
            m_serr[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [DIGITS-1:0] an, input logic [0:6] sg, input logic r);
        int idx;
        logic [3:0] v;
        logic e;
        if (m_cpend) begin
            if (!m_fv || r) begin
                m_dig = m_fd; m_err = m_fe;
                if (m_fv) m_ovr = 1'b0;
                m_fv = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            m_cpend = 1'b0;
        end else if (m_fv && r) begin
            m_fv = 1'b0; m_ovr = 1'b0;
        end
        if ($countones(~m_prev_an) == 1) begin
            if (m_prev_an == m_prev2_an && m_prev_seg == m_prev2_seg) m_run++;
            else m_run = 1;
            if (m_run == STABLE) begin
                idx = 0;
                for (int i = 0; i < DIGITS; i++) if (!m_prev_an[i]) idx = i;
                v = 4'hF; e = 1'b1;
                for (int d = 0; d < 10; d++) begin
                    if (gl(d) == m_prev_seg) begin
                        v = 4'(d); e = 1'b0;
                    end
                end
                m_slot[idx] = v; m_serr[idx] = e;
                m_mask[idx] = 1'b1;
                if (&m_mask) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        m_fd[4*i +: 4] = m_slot[i];
                        m_fe[i] = m_serr[i];
                    end
                    m_mask = '0;
                    m_cpend = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        m_prev2_an = m_prev_an; m_prev2_seg = m_prev_seg;
        m_prev_an = an; m_prev_seg = sg;
    endtask

    int                  acc_cnt = 0;
    logic [4*DIGITS-1:0] acc_digits = '0;
    logic [DIGITS-1:0]   acc_err = '0;

    task automatic cyc(input logic [DIGITS-1:0] an, input logic [0:6] sg);
        logic fvb;
        logic [4*DIGITS-1:0] db;
        logic [DIGITS-1:0] eb;
        an_n = an; seg_n = sg;
        fvb = frame_valid; db = digits; eb = err;
        @(posedge clk);
        if (fvb && frame_ready) begin
            acc_cnt++; acc_digits = db; acc_err = eb;
            $display("frame %0d accepted: digits=%h err=%b", acc_cnt, db, eb);
        end
        model_edge(an, sg, frame_ready);
        #1;
        chk("digits", 32'(digits), 32'(m_dig));
        chk("err", 32'(err), 32'(m_err));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic show(input logic [DIGITS-1:0] an, input logic [0:6] sg, input int n);
        for (int k = 0; k < n; k++) cyc(an, sg);
    endtask

    // Scan digits 0..3 with glyphs d0..d3, then idle long enough to complete
    task automatic scan(input int d0, input int d1, input int d2, input int d3);
        show(4'b1110, gl(d0), 6);
        show(4'b1101, gl(d1), 6);
        show(4'b1011, gl(d2), 6);
        show(4'b0111, gl(d3), 6);
        show(4'b1111, 7'b1111111, 3);
    endtask

    initial begin
        int c0, d, len;
        logic [DIGITS-1:0] an;
        logic [0:6] g;

        rst_n = 1'b0; an_n = '1; seg_n = '1; frame_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean scan, consumer always ready
        frame_ready = 1'b1;
        c0 = acc_cnt;
        scan(1, 2, 3, 4);
        chk("clean_frames", 32'(acc_cnt - c0), 32'd1);
        chk("clean_digits", 32'(acc_digits), 32'h4321);
        chk("clean_err", 32'(acc_err), 32'h0);

        // Glitch rejection on digit 0
        show(4'b1110, gl(0), 3);
        show(4'b1110, gl(3), 5);
        show(4'b1101, gl(5), 6);
        show(4'b1011, gl(6), 6);
        show(4'b0111, gl(7), 6);
        show(4'b1111, 7'b1111111, 3);
        chk("glitch_digits", 32'(acc_digits), 32'h7653);

        // Illegal glyph on digit 2 with ghosting samples between digits
        show(4'b1110, gl(0), 6);
        show(4'b1100, gl(8), 6);
        show(4'b1101, gl(1), 6);
        show(4'b1100, gl(8), 3);
        show(4'b1011, 7'b1111111, 6);
        show(4'b0111, gl(9), 6);
        show(4'b1111, 7'b1111111, 3);
        chk("illegal_digits", 32'(acc_digits), 32'h9F10);
        chk("illegal_err", 32'(acc_err), 32'h4);

        // Backpressure across two scans
        frame_ready = 1'b0;
        scan(5, 6, 7, 8);
        scan(1, 1, 1, 1);
        chk("bp_digits", 32'(digits), 32'h8765);
        chk("bp_fv", 32'(frame_valid), 32'h1);
        chk("bp_ovr", 32'(overrun), 32'h1);
        frame_ready = 1'b1;
        cyc(4'b1111, 7'b1111111);
        frame_ready = 1'b0;
        chk("bp_acc_fv", 32'(frame_valid), 32'h0);
        chk("bp_acc_ovr", 32'(overrun), 32'h0);

        // Accept on the same edge the next frame completes
        scan(2, 4, 6, 8);
        show(4'b1110, gl(9), 6);
        show(4'b1101, gl(8), 6);
        show(4'b1011, gl(7), 6);
        for (int k = 0; k < 9; k++) begin
            frame_ready = m_cpend;
            cyc(k < 6 ? 4'b0111 : 4'b1111, k < 6 ? gl(6) : 7'b1111111);
        end
        frame_ready = 1'b0;
        chk("sim_digits", 32'(digits), 32'h6789);
        chk("sim_fv", 32'(frame_valid), 32'h1);
        chk("sim_ovr", 32'(overrun), 32'h0);

        // Reset in the middle of a settle window
        show(4'b1110, gl(1), 6);
        show(4'b1101, gl(2), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_digits", 32'(digits), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_fv", 32'(frame_valid), 32'h0);
        chk("mid_rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        show(4'b1101, gl(2), 6);
        show(4'b1011, gl(3), 6);
        show(4'b0111, gl(4), 6);
        show(4'b1111, 7'b1111111, 3);
        chk("rst_no_partial", 32'(frame_valid), 32'h0);
        c0 = acc_cnt;
        show(4'b1110, gl(1), 6);
        show(4'b1111, 7'b1111111, 3);
        chk("rst_frames", 32'(acc_cnt - c0), 32'd1);
        chk("rst_digits_after", 32'(acc_digits), 32'h4321);

        // Randomized scanning with random backpressure
        for (int t = 0; t < 500; t++) begin
            d = $urandom_range(0, 9);
            g = ($urandom_range(0, 9) == 0) ? 7'($urandom()) : gl(d);
            if ($urandom_range(0, 9) == 0) an = 4'($urandom());
            else an = ~(4'b0001 << $urandom_range(0, DIGITS - 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                frame_ready = ($urandom_range(0, 3) != 0);
                cyc(an, g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
